uart_tx_fifo_drain: RTL



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/uart_tx_fifo_drain.sv | 117 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int unsigned FRAME_BITS = 10;

  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Free-running 0..DIV-1 bit-period counter with synchronous clear and terminal-count pulse.
module uart_baud_cnt #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// Drains a byte FIFO and serialises each byte as an 8N1 UART frame on tx.
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_pop_data,
  output logic                  fifo_pop,
  output logic                  tx,
  output logic                  busy
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  if (DIV < 2) begin : g_div_check
    $error("uart_tx_fifo_drain: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  uart_tx_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  pop_q, pop_d;
  logic                  baud_clear;
  logic                  tick;

  uart_baud_cnt #(
    .DIV(DIV)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(baud_clear),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    baud_clear = (state_q == IDLE) || (state_q == PREP);

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = PREP;
        end
      end
      PREP: begin
        shift_d = fifo_pop_data;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_WIDTH - 1)) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = fifo_empty ? IDLE : PREP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up with the state.
    pop_d  = (state_d == PREP);
    busy_d = (state_d != IDLE);
    tx_d   = 1'b1;
    if (state_d == START) begin
      tx_d = 1'b0;
    end else if (state_d == DATA) begin
      tx_d = shift_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      pop_q   <= pop_d;
    end
  end

  assign fifo_pop = pop_q;
  assign tx       = tx_q;
  assign busy     = busy_q;

endmodule
